// File: rtl/wb_matrix_slave.sv
// Wishbone responder for the matrix accelerator: control registers, A/B operand
// arrays, engine-written C array and the start/done handshake with the engine.
module wb_matrix_slave #(
   parameter int DIM_BITS = 4,
   parameter int DATA_W   = 32
) (
   input  logic                  wishbone_clk_i,
   input  logic                  wishbone_rst_i,
   input  logic [31:0]           wishbone_addr_i,
   input  logic                  wishbone_we_i,
   input  logic [DATA_W-1:0]     wishbone_data_i,
   output logic [DATA_W-1:0]     wishbone_data_o,
   input  logic                  wishbone_stb,
   output logic                  wishbone_ack,
   output logic                  eng_start,
   output logic [31:0]           eng_op,
   output logic [31:0]           eng_wa,
   output logic [31:0]           eng_ha,
   output logic [31:0]           eng_wb,
   output logic [31:0]           eng_hb,
   input  logic [2*DIM_BITS-1:0] eng_a_addr,
   input  logic [2*DIM_BITS-1:0] eng_b_addr,
   output logic [DATA_W-1:0]     eng_a_data,
   output logic [DATA_W-1:0]     eng_b_data,
   input  logic                  eng_c_we,
   input  logic [2*DIM_BITS-1:0] eng_c_addr,
   input  logic [DATA_W-1:0]     eng_c_data,
   input  logic                  eng_done
);

   localparam int N     = 1 << DIM_BITS;
   localparam int IW    = 2 * DIM_BITS;
   localparam int DEPTH = 1 << IW;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STALL   = 2'd1,
      S_ACK     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_ack, r_start, r_go_pend;
   logic [DATA_W-1:0] r_rdata;
   logic [31:0]       r_op, r_wa, r_ha, r_wb, r_hb;
   logic              r_busy, r_done, r_err;
   logic [DATA_W-1:0] r_mem_a [DEPTH];
   logic [DATA_W-1:0] r_mem_b [DEPTH];
   logic [DATA_W-1:0] r_mem_c [DEPTH];

   logic [1:0]        w_region;
   logic [14:0]       w_row, w_col;
   logic              w_in_range;
   logic [IW-1:0]     w_idx;
   logic [2:0]        w_reg_idx;
   logic              w_commit, w_wr, w_a_we, w_b_we, w_c_we, w_ctrl_we;
   logic              w_go, w_go_ok, w_go_bad, w_dims_ok;
   logic [DATA_W-1:0] w_rdata;

   function automatic logic dim_ok(input logic [31:0] d);
      return (d >= 32'd1) && (d <= 32'(N));
   endfunction

   // Address decode, commit qualification and write enables
   always_comb begin
      w_region   = wishbone_addr_i[31:30];
      w_row      = wishbone_addr_i[29:15];
      w_col      = wishbone_addr_i[14:0];
      w_reg_idx  = wishbone_addr_i[2:0];
      w_in_range = (w_row < 15'(N)) && (w_col < 15'(N));
      w_idx      = {w_row[DIM_BITS-1:0], w_col[DIM_BITS-1:0]};
      w_dims_ok  = dim_ok(r_wa) && dim_ok(r_ha) && dim_ok(r_wb) && dim_ok(r_hb) && (r_wa == r_hb);
      case (r_state)
         S_IDLE:  w_commit = wishbone_stb && !((w_region == 2'b11) && r_busy);
         // A done pulse releases the stall in the same cycle it arrives
         S_STALL: w_commit = !r_busy || eng_done;
         default: w_commit = 1'b0;
      endcase
      w_wr      = w_commit && wishbone_we_i && !wishbone_rst_i;
      w_a_we    = w_wr && (w_region == 2'b01) && w_in_range && !r_busy;
      w_b_we    = w_wr && (w_region == 2'b10) && w_in_range && !r_busy;
      w_c_we    = eng_c_we && r_busy && !wishbone_rst_i;
      w_ctrl_we = w_wr && (w_region == 2'b00) && !r_busy;
      w_go      = w_ctrl_we && (w_reg_idx == 3'd5) && (wishbone_data_i != {DATA_W{1'b0}});
      w_go_ok   = w_go && w_dims_ok;
      w_go_bad  = w_go && !w_dims_ok;
   end

   // Read data selection for the addressed location
   always_comb begin
      w_rdata = {DATA_W{1'b0}};
      case (w_region)
         2'b00: begin
            case (w_reg_idx)
               3'd0:    w_rdata = DATA_W'(r_op);
               3'd1:    w_rdata = DATA_W'(r_wa);
               3'd2:    w_rdata = DATA_W'(r_ha);
               3'd3:    w_rdata = DATA_W'(r_wb);
               3'd4:    w_rdata = DATA_W'(r_hb);
               3'd6:    w_rdata = DATA_W'({29'd0, r_err, r_done, r_busy});
               default: w_rdata = {DATA_W{1'b0}};
            endcase
         end
         2'b01: begin
            if (w_in_range) w_rdata = r_mem_a[w_idx];
            else            w_rdata = {DATA_W{1'b0}};
         end
         2'b10: begin
            if (w_in_range) w_rdata = r_mem_b[w_idx];
            else            w_rdata = {DATA_W{1'b0}};
         end
         default: begin
            if (w_in_range) w_rdata = r_mem_c[w_idx];
            else            w_rdata = {DATA_W{1'b0}};
         end
      endcase
   end

   // Bus handshake FSM, control/status registers and engine launch/completion
   always_ff @(posedge wishbone_clk_i) begin
      if (wishbone_rst_i) begin
         r_state   <= S_IDLE;
         r_ack     <= 1'b0;
         r_rdata   <= {DATA_W{1'b0}};
         r_start   <= 1'b0;
         r_go_pend <= 1'b0;
         r_op      <= 32'd0;
         r_wa      <= 32'd0;
         r_ha      <= 32'd0;
         r_wb      <= 32'd0;
         r_hb      <= 32'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ack     <= 1'b0;
         r_start   <= r_go_pend;
         r_go_pend <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_commit) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end else if (wishbone_stb) begin
                  r_state <= S_STALL;
               end
            end
            S_STALL: begin
               if (w_commit) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end
            end
            S_ACK:     r_state <= S_RELEASE;
            S_RELEASE: if (!wishbone_stb) r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
         if (w_commit && !wishbone_we_i) r_rdata <= w_rdata;
         if (w_ctrl_we) begin
            case (w_reg_idx)
               3'd0:    r_op <= 32'(wishbone_data_i);
               3'd1:    r_wa <= 32'(wishbone_data_i);
               3'd2:    r_ha <= 32'(wishbone_data_i);
               3'd3:    r_wb <= 32'(wishbone_data_i);
               3'd4:    r_hb <= 32'(wishbone_data_i);
               default: r_op <= r_op;
            endcase
         end
         if (w_go_ok) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_go_pend <= 1'b1;
         end else if (w_go_bad) begin
            r_err <= 1'b1;
         end
         if (eng_done && r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   // Operand and result array storage (contents survive reset)
   always_ff @(posedge wishbone_clk_i) begin
      if (w_a_we) r_mem_a[w_idx] <= wishbone_data_i;
      if (w_b_we) r_mem_b[w_idx] <= wishbone_data_i;
      if (w_c_we) r_mem_c[eng_c_addr] <= eng_c_data;
   end

   assign wishbone_ack    = r_ack;
   assign wishbone_data_o = r_rdata;
   assign eng_start       = r_start;
   assign eng_op          = r_op;
   assign eng_wa          = r_wa;
   assign eng_ha          = r_ha;
   assign eng_wb          = r_wb;
   assign eng_hb          = r_hb;
   assign eng_a_data      = r_mem_a[eng_a_addr];
   assign eng_b_data      = r_mem_b[eng_b_addr];

endmodule
